// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - 8N1 UART receiver that packs bytes into program memory write words
// Four accepted bytes form one little-endian word, presented with its byte address on a one-cycle strobe.
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_rx,
  output logic        data_valid,
  output logic [31:0] data_out,
  output logic [31:0] byte_address,
  output logic        frame_error
);

  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic             rx_meta_q, rx_s_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_ok;
  logic             frame_error_q, frame_error_d;

  logic [TO_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic             timeout;

  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      shadow_q, shadow_d, shadow_ins;
  logic [31:0]      data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic [31:0]      addr_q, addr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= io_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      clk_cnt_q     <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      frame_error_q <= 1'b0;
      idle_cnt_q    <= '0;
      byte_cnt_q    <= '0;
      shadow_q      <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      addr_q        <= '0;
    end else begin
      state_q       <= state_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      frame_error_q <= frame_error_d;
      idle_cnt_q    <= idle_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      shadow_q      <= shadow_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      addr_q        <= addr_d;
    end
  end

  // Receiver FSM; clk_cnt defaults to zero so every state change clears it.
  always_comb begin
    state_d       = state_q;
    clk_cnt_d     = '0;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    byte_ok       = 1'b0;
    frame_error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          if (rx_s_q) begin
            byte_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = S_WAIT_HIGH;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Idle timeout fires even on the clock a start bit is seen, so that byte starts a fresh word.
  always_comb begin
    idle_cnt_d = '0;
    timeout    = 1'b0;
    if (state_q == S_IDLE && byte_cnt_q != 2'd0) begin
      if (idle_cnt_q == TO_LAST) timeout = 1'b1;
      else if (rx_s_q)           idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_comb begin
    shadow_ins = shadow_q;
    shadow_ins[{byte_cnt_q, 3'b000} +: 8] = shift_q;

    byte_cnt_d   = byte_cnt_q;
    shadow_d     = shadow_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    addr_d       = data_valid_q ? addr_q + 32'd4 : addr_q;

    if (timeout) begin
      byte_cnt_d = '0;
      shadow_d   = '0;
    end else if (byte_ok) begin
      shadow_d = shadow_ins;
      if (byte_cnt_q == 2'd3) begin
        data_out_d   = shadow_ins;
        data_valid_d = 1'b1;
        byte_cnt_d   = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end
  end

  assign data_valid   = data_valid_q;
  assign data_out     = data_out_q;
  assign byte_address = addr_q;
  assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - self-checking bench for uart_program_loader
// Byte-level model predicts each strobe's cycle, word and address; a compare process checks every cycle.
module tb_uart_program_loader;

  localparam int CPB      = 4;
  localparam int TOB      = 2;
  localparam int STROBE_LAT = 41;
  localparam int LONG_GAP = TOB * CPB + 4;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        io_rx;
  logic        data_valid;
  logic [31:0] data_out;
  logic [31:0] byte_address;
  logic        frame_error;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .io_rx        (io_rx),
    .data_valid   (data_valid),
    .data_out     (data_out),
    .byte_address (byte_address),
    .frame_error  (frame_error)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  exp_t        exp_q[$];
  int          fe_q[$];
  logic [7:0]  mlane[4];
  int          mcnt  = 0;
  logic [31:0] maddr = 0;

  logic [31:0] cur_data = 0;
  logic [31:0] cur_addr = 0;
  logic [31:0] cap_data = 0;
  logic [31:0] cap_addr = 0;
  int          dv_seen  = 0;
  int          fe_seen  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cur_data = '0;
        cur_addr = '0;
      end else begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          chk("data_valid", {31'd0, data_valid}, 32'd1);
          chk("data_out@strobe", data_out, exp_q[0].data);
          chk("byte_address@strobe", byte_address, exp_q[0].addr);
          cur_data = exp_q[0].data;
          cur_addr = exp_q[0].addr + 32'd4;
          void'(exp_q.pop_front());
        end else begin
          chk("data_valid", {31'd0, data_valid}, 32'd0);
          chk("data_out_hold", data_out, cur_data);
          chk("byte_address_hold", byte_address, cur_addr);
        end
        if (fe_q.size() > 0 && fe_q[0] == cyc) begin
          chk("frame_error", {31'd0, frame_error}, 32'd1);
          void'(fe_q.pop_front());
        end else begin
          chk("frame_error", {31'd0, frame_error}, 32'd0);
        end
        if (data_valid) begin
          cap_data = data_out;
          cap_addr = byte_address;
          dv_seen++;
        end
        if (frame_error) fe_seen++;
      end
    end
  end

  // Called on a falling edge; the strobe for this byte is due STROBE_LAT cycles later.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    int c0;
    c0 = cyc;
    if (stop_ok) begin
      mlane[mcnt] = b;
      if (mcnt == 3) begin
        exp_q.push_back('{c0 + STROBE_LAT, {mlane[3], mlane[2], mlane[1], mlane[0]}, maddr});
        maddr = maddr + 32'd4;
        mcnt  = 0;
      end else begin
        mcnt++;
      end
    end else begin
      fe_q.push_back(c0 + STROBE_LAT);
    end
    io_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      io_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    io_rx = stop_ok;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic idle_gap(input int n);
    io_rx = 1'b1;
    if (n >= LONG_GAP) mcnt = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    mcnt    = 0;
    maddr   = '0;
    exp_q.delete();
    fe_q.delete();
    dv_seen = 0;
    fe_seen = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    io_rx   = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() + fe_q.size()) != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain", exp_q.size() + fe_q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    io_rx   = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset data_valid", {31'd0, data_valid}, 32'd0);
    chk("reset data_out", data_out, 32'd0);
    chk("reset byte_address", byte_address, 32'd0);
    chk("reset frame_error", {31'd0, frame_error}, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic word
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    idle_gap(2);
    wait_drain();
    chk("basic word", cap_data, 32'h12345678);
    chk("basic addr", cap_addr, 32'd0);
    chk("basic addr after", byte_address, 32'd4);
    chk("basic strobes", dv_seen, 32'd1);

    // Three words, run-start marker last
    do_reset();
    send_word(32'hDDCCBBAA);
    send_word(32'h44332211);
    send_word(32'h00001111);
    idle_gap(2);
    wait_drain();
    chk("three strobes", dv_seen, 32'd3);
    chk("three last word", cap_data, 32'h00001111);
    chk("three last addr", cap_addr, 32'd8);
    chk("three frame errs", fe_seen, 32'd0);

    // Frame error keeps earlier lanes
    do_reset();
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    idle_gap(CPB);
    send_byte(8'hD4, 1'b1);
    send_byte(8'hE5, 1'b1);
    idle_gap(2);
    wait_drain();
    chk("ferr pulses", fe_seen, 32'd1);
    chk("ferr strobes", dv_seen, 32'd1);
    chk("ferr word", cap_data, 32'hE5D4B2A1);
    chk("ferr addr", cap_addr, 32'd0);

    // False start
    do_reset();
    io_rx = 1'b0;
    @(negedge clk);
    idle_gap(10);
    send_word(32'h87654321);
    idle_gap(2);
    wait_drain();
    chk("false start ferr", fe_seen, 32'd0);
    chk("false start strobes", dv_seen, 32'd1);
    chk("false start word", cap_data, 32'h87654321);
    chk("false start addr", cap_addr, 32'd0);

    // Timeout discards a partial word
    do_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle_gap(20);
    send_word(32'hDEADBEEF);
    idle_gap(2);
    wait_drain();
    chk("timeout strobes", dv_seen, 32'd1);
    chk("timeout word", cap_data, 32'hDEADBEEF);
    chk("timeout addr", cap_addr, 32'd0);

    // Reset mid-byte of the second word
    do_reset();
    send_word(32'h0BADF00D);
    send_byte(8'h01, 1'b1);
    io_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    io_rx = 1'b1;
    repeat (6) @(negedge clk);
    wait_drain();
    chk("pre-reset addr", byte_address, 32'd4);
    io_rx = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset data_valid", {31'd0, data_valid}, 32'd0);
    chk("midreset data_out", data_out, 32'd0);
    chk("midreset byte_address", byte_address, 32'd0);
    chk("midreset frame_error", {31'd0, frame_error}, 32'd0);
    io_rx = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle_gap(3);
    send_word(32'hCAFEF00D);
    idle_gap(2);
    wait_drain();
    chk("post-reset word", cap_data, 32'hCAFEF00D);
    chk("post-reset addr", cap_addr, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
